pb_wire_sequencer: RTL and testbench
====================================

// Module: pb_wire_sequencer
// PURPOSE
//  Streaming hardware front end for the protobuf wire-format decoder.
//  - Consumes a message byte stream and sequences key -> value decode per field.
//  - Emits one field event per known field; streams length-delimited payloads.
//  - Consumes and drops unknown fields.
//  - Sits between the DMA byte source and the per-message field sinks.
// PARAMETERS
//  FIELD_W      5   width of field number; field numbers >= 2**FIELD_W are unknown
//  MAX_VARINT   10  max varint bytes (ceil(64/7)); one more is an error
//  LEN_W        16  width of the length-delimited byte counter
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  in_valid     in   1        input byte valid
//  in_ready     out  1        input byte accepted when in_valid&&in_ready
//  in_data      in   8        input byte
//  in_last      in   1        last byte of message
//  known_mask   in   2**FIELD_W  bit n=1: field n is emitted; 0: skipped (static per message)
//  fld_valid    out  1        field event valid
//  fld_ready    in   1        field event accepted
//  fld_num      out  FIELD_W  field number
//  fld_wt       out  3        wire type 0/1/2/5
//  fld_value    out  64       varint/fixed value (LE); wt2: payload length
//  pay_valid    out  1        wt2 payload byte valid (no ready; follows in_ready)
//  pay_data     out  8        payload byte
//  pay_last     out  1        final payload byte of field
//  err          out  1        one-cycle pulse on decode error
//  err_code     out  2        1 varint overflow, 2 illegal wire type, 3 truncated
// BEHAVIOUR
//  - Reset: state KEY. All outputs 0, except in_ready=1.
//  - FSM states: KEY, VARINT, FIX, LEN, PAYLOAD, SKIP, EMIT, DRAIN.
//  - KEY: accumulate the key varint, 7 bits per byte, LSB group first.
//    On the byte with bit7=0: fnum=key>>3, wt=key[2:0].
//    - wt 0 -> VARINT; 1 -> FIX (cnt=8); 5 -> FIX (cnt=4); 2 -> LEN.
//    - wt 3/4/6/7: err code 2, then DRAIN.
//  - known = (key>>3) < 2**FIELD_W && known_mask[fnum].
//    Unknown fields decode identically but suppress fld/pay outputs.
//  - VARINT: shift-accumulate into a 64-bit value; bits beyond 64 are discarded.
//    - Terminating byte -> EMIT if known, else KEY.
//    - Byte MAX_VARINT+1 with bit7 still 1: err code 1, then DRAIN. Applies to key and LEN varints too.
//  - FIX: little-endian byte assembly, cnt down to 0 -> EMIT/KEY. Upper bits are zero for wt5.
//  - LEN: varint, truncated to LEN_W.
//    - Known: EMIT header (fld_value=len), then PAYLOAD.
//    - Unknown: SKIP.
//    - len==0: header only, then KEY; no pay_valid.
//  - PAYLOAD: each accepted byte gives pay_valid=1 the same cycle, pay_data=in_data.
//    pay_last asserts on the byte where remaining==1; then KEY.
//  - SKIP: consume len bytes silently, then KEY.
//  - EMIT: fld_valid=1, in_ready=0 until fld_ready. Outputs stay stable while stalled.
//    - Next state: KEY, or PAYLOAD for wt2 with len>0.
//    - Latency: fld_valid is registered, 1 cycle after the terminating byte.
//  - in_last on a byte completing a field: normal completion, next state KEY.
//    EMIT still occurs if the field is known.
//  - in_last mid-field (any state but KEY-at-first-byte): err code 3.
//    Partial field is not emitted; next state KEY.
//  - DRAIN: in_ready=1, discard bytes until the in_last byte, then KEY.
//  - err is a registered 1-cycle pulse; err_code holds until the next err.
//  - Reset mid-message: abandons the field and clears all counters. No event for a partial field.
// CONFIGURATION
//  - PB_SKIP_STATS_EN defined: adds outputs skip_cnt[15:0] and err_cnt[15:0].
//    - skip_cnt counts unknown fields, +1 at each unknown field completion.
//    - err_cnt counts err pulses.
//    - Both saturate at 16'hFFFF and reset to 0.
//  - Undefined: these ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
//  - pb_pkg holds:
//    - wire_type_e (VARINT=0, I64=1, LEN=2, SGROUP=3, EGROUP=4, I32=5)
//    - pb_err_e
//    - the sequencer state enum
//    - MAX_VARINT_BYTES
//  - Sub-module pb_varint_accum: byte-serial varint shift/accumulate.
//    Flags done/overflow; clear input. Shared by the KEY, VARINT and LEN states.
// TESTING
//  - Bytes 08 96 01 (last), mask bit1=1 -> one event: num=1, wt=0, value=150.
//  - 12 03 61 62 63, mask bit2=1 -> header len=3.
//    Then pay 61,62,63 with pay_last on 63.
//  - 1D 01 02 03 04 then 08 05, mask bit3=0 bit1=1 -> fixed32 skipped.
//    Single event num=1 value=5. skip_cnt=1 with the macro defined.
//  - 08 followed by 11 bytes of FF -> err code 1 on 11th FF.
//    Bytes dropped until in_last; next message decodes normally.
//  - Key 0B (wt3) -> err code 2. Separately, 12 05 61 with in_last on 61 -> err code 3, no pay_last.
//  - 08 96 01 with fld_ready held 0 for 5 cycles -> in_ready=0 and event stable throughout.
//    Accepted on release; the following key byte is then consumed.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types for the protobuf wire-format front end: wire types, error codes,
// sequencer states and varint limits.
package pb_pkg;

    localparam int unsigned MAX_VARINT_BYTES = 10;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_SGROUP = 3'd3,
        WT_EGROUP = 3'd4,
        WT_I32    = 3'd5
    } wire_type_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_OVERFLOW   = 2'd1,
        ERR_ILLEGAL_WT = 2'd2,
        ERR_TRUNCATED  = 2'd3
    } pb_err_e;

    typedef enum logic [2:0] {
        ST_KEY,
        ST_VARINT,
        ST_FIX,
        ST_LEN,
        ST_PAYLOAD,
        ST_SKIP,
        ST_EMIT,
        ST_DRAIN
    } seq_state_e;

    // Groups (3/4) and the reserved codes 6/7 are not decodable.
    function automatic logic is_legal_wt(input logic [2:0] wt);
        return (wt == WT_VARINT) || (wt == WT_I64) || (wt == WT_LEN) || (wt == WT_I32);
    endfunction

endpackage

// File: rtl/pb_varint_accum.sv
// Byte-serial varint accumulator: 7 bits per byte, LSB group first, bits past 64
// discarded. Flags the terminating byte and the byte that exceeds MAX_BYTES.
module pb_varint_accum
    import pb_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_VARINT_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [63:0] value_c,
    output logic        done_c,
    output logic        overflow_c
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned SH_W  = $clog2(7 * MAX_BYTES + 1);

    logic [63:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SH_W-1:0]  shamt;

    assign shamt      = SH_W'(cnt_q) * SH_W'(7);
    assign value_c    = acc_q | (64'(data[6:0]) << shamt);
    assign done_c     = en && !data[7];
    assign overflow_c = en && data[7] && (cnt_q == CNT_W'(MAX_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (en) begin
            acc_q <= value_c;
            if (cnt_q != CNT_W'(MAX_BYTES)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pb_wire_sequencer.sv
// Protobuf wire-format sequencer: decodes key/value per field, emits known fields,
// streams length-delimited payloads, drops unknown fields. PB_SKIP_STATS_EN adds counters.
module pb_wire_sequencer
    import pb_pkg::*;
#(
    parameter int unsigned FIELD_W    = 5,
    parameter int unsigned MAX_VARINT = MAX_VARINT_BYTES,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    input  logic [(1<<FIELD_W)-1:0]   known_mask,
    output logic                      fld_valid,
    input  logic                      fld_ready,
    output logic [FIELD_W-1:0]        fld_num,
    output logic [2:0]                fld_wt,
    output logic [63:0]               fld_value,
    output logic                      pay_valid,
    output logic [7:0]                pay_data,
    output logic                      pay_last,
    output logic                      err,
    output logic [1:0]                err_code
`ifdef PB_SKIP_STATS_EN
    ,
    output logic [15:0]               skip_cnt,
    output logic [15:0]               err_cnt
`endif
);

    seq_state_e           state_q, state_d;
    logic [FIELD_W-1:0]   fnum_q, fnum_d;
    logic [2:0]           wt_q, wt_d;
    logic                 known_q, known_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [63:0]          fix_q, fix_d;

    logic                 in_ready_d, fld_valid_d, err_d;
    logic [FIELD_W-1:0]   fld_num_d;
    logic [2:0]           fld_wt_d;
    logic [63:0]          fld_value_d;
    logic [1:0]           err_code_d;
    logic                 skip_evt_c;

    logic                 accept_c, acc_en_c, acc_clear_c, acc_done_c, acc_ovf_c;
    logic [63:0]          acc_value_c;
    logic [FIELD_W-1:0]   key_fnum_c;
    logic [2:0]           key_wt_c;
    logic                 key_known_c;
    logic [LEN_W-1:0]     len_c;
    logic [63:0]          fix_next_c, fix_final_c;

    assign accept_c    = in_valid && in_ready;
    assign acc_en_c    = accept_c && ((state_q == ST_KEY) || (state_q == ST_VARINT) || (state_q == ST_LEN));
    // Accumulator only keeps its contents while a varint is still in flight.
    assign acc_clear_c = !(acc_en_c && !acc_done_c && !acc_ovf_c && !in_last);

    pb_varint_accum #(.MAX_BYTES(MAX_VARINT)) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (acc_clear_c),
        .en         (acc_en_c),
        .data       (in_data),
        .value_c    (acc_value_c),
        .done_c     (acc_done_c),
        .overflow_c (acc_ovf_c)
    );

    assign key_fnum_c  = acc_value_c[FIELD_W+2:3];
    assign key_wt_c    = acc_value_c[2:0];
    assign key_known_c = (acc_value_c[63:FIELD_W+3] == '0) && known_mask[key_fnum_c];
    assign len_c       = acc_value_c[LEN_W-1:0];
    // Fixed fields shift in from the top; a fixed32 ends up in the upper half.
    assign fix_next_c  = {in_data, fix_q[63:8]};
    assign fix_final_c = (wt_q == WT_I32) ? {32'h0, fix_next_c[63:32]} : fix_next_c;

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        fnum_d      = fnum_q;
        wt_d        = wt_q;
        known_d     = known_q;
        cnt_d       = cnt_q;
        fix_d       = fix_q;
        fld_valid_d = fld_valid;
        fld_num_d   = fld_num;
        fld_wt_d    = fld_wt;
        fld_value_d = fld_value;
        err_d       = 1'b0;
        err_code_d  = err_code;
        skip_evt_c  = 1'b0;
        pay_valid   = 1'b0;
        pay_data    = 8'h00;
        pay_last    = 1'b0;

        case (state_q)
            ST_KEY: begin
                if (accept_c) begin
                    if (acc_ovf_c) begin
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_OVERFLOW);
                        state_d    = in_last ? ST_KEY : ST_DRAIN;
                    end else if (acc_done_c) begin
                        fnum_d  = key_fnum_c;
                        wt_d    = key_wt_c;
                        known_d = key_known_c;
                        if (!is_legal_wt(key_wt_c)) begin
                            err_d      = 1'b1;
                            err_code_d = 2'(ERR_ILLEGAL_WT);
                            state_d    = in_last ? ST_KEY : ST_DRAIN;
                        end else if (in_last) begin
                            err_d      = 1'b1;
                            err_code_d = 2'(ERR_TRUNCATED);
                        end else begin
                            case (key_wt_c)
                                WT_I64: begin
                                    state_d = ST_FIX;
                                    cnt_d   = LEN_W'(8);
                                end
                                WT_I32: begin
                                    state_d = ST_FIX;
                                    cnt_d   = LEN_W'(4);
                                end
                                WT_LEN:  state_d = ST_LEN;
                                default: state_d = ST_VARINT;
                            endcase
                        end
                    end else if (in_last) begin
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_TRUNCATED);
                    end
                end
            end
            ST_VARINT: begin
                if (accept_c) begin
                    if (acc_ovf_c) begin
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_OVERFLOW);
                        state_d    = in_last ? ST_KEY : ST_DRAIN;
                    end else if (acc_done_c) begin
                        if (known_q) begin
                            state_d     = ST_EMIT;
                            fld_valid_d = 1'b1;
                            fld_num_d   = fnum_q;
                            fld_wt_d    = wt_q;
                            fld_value_d = acc_value_c;
                        end else begin
                            skip_evt_c = 1'b1;
                            state_d    = ST_KEY;
                        end
                    end else if (in_last) begin
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_TRUNCATED);
                        state_d    = ST_KEY;
                    end
                end
            end
            ST_FIX: begin
                if (accept_c) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        fix_d = '0;
                        if (known_q) begin
                            state_d     = ST_EMIT;
                            fld_valid_d = 1'b1;
                            fld_num_d   = fnum_q;
                            fld_wt_d    = wt_q;
                            fld_value_d = fix_final_c;
                        end else begin
                            skip_evt_c = 1'b1;
                            state_d    = ST_KEY;
                        end
                    end else if (in_last) begin
                        fix_d      = '0;
                        cnt_d      = '0;
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_TRUNCATED);
                        state_d    = ST_KEY;
                    end else begin
                        fix_d = fix_next_c;
                    end
                end
            end
            ST_LEN: begin
                if (accept_c) begin
                    if (acc_ovf_c) begin
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_OVERFLOW);
                        state_d    = in_last ? ST_KEY : ST_DRAIN;
                    end else if (acc_done_c) begin
                        if (in_last && (len_c != '0)) begin
                            err_d      = 1'b1;
                            err_code_d = 2'(ERR_TRUNCATED);
                            state_d    = ST_KEY;
                        end else if (known_q) begin
                            cnt_d       = len_c;
                            state_d     = ST_EMIT;
                            fld_valid_d = 1'b1;
                            fld_num_d   = fnum_q;
                            fld_wt_d    = wt_q;
                            fld_value_d = 64'(len_c);
                        end else if (len_c == '0) begin
                            skip_evt_c = 1'b1;
                            state_d    = ST_KEY;
                        end else begin
                            cnt_d   = len_c;
                            state_d = ST_SKIP;
                        end
                    end else if (in_last) begin
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_TRUNCATED);
                        state_d    = ST_KEY;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept_c) begin
                    pay_valid = 1'b1;
                    pay_data  = in_data;
                    cnt_d     = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        pay_last = 1'b1;
                        state_d  = ST_KEY;
                    end else if (in_last) begin
                        cnt_d      = '0;
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_TRUNCATED);
                        state_d    = ST_KEY;
                    end
                end
            end
            ST_SKIP: begin
                if (accept_c) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        skip_evt_c = 1'b1;
                        state_d    = ST_KEY;
                    end else if (in_last) begin
                        cnt_d      = '0;
                        err_d      = 1'b1;
                        err_code_d = 2'(ERR_TRUNCATED);
                        state_d    = ST_KEY;
                    end
                end
            end
            ST_EMIT: begin
                if (fld_ready) begin
                    fld_valid_d = 1'b0;
                    state_d     = ((wt_q == WT_LEN) && (cnt_q != '0)) ? ST_PAYLOAD : ST_KEY;
                end
            end
            ST_DRAIN: begin
                if (accept_c && in_last) begin
                    state_d = ST_KEY;
                end
            end
            default: state_d = ST_KEY;
        endcase

        in_ready_d = (state_d != ST_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_KEY;
            fnum_q    <= '0;
            wt_q      <= '0;
            known_q   <= 1'b0;
            cnt_q     <= '0;
            fix_q     <= '0;
            in_ready  <= 1'b1;
            fld_valid <= 1'b0;
            fld_num   <= '0;
            fld_wt    <= '0;
            fld_value <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            state_q   <= state_d;
            fnum_q    <= fnum_d;
            wt_q      <= wt_d;
            known_q   <= known_d;
            cnt_q     <= cnt_d;
            fix_q     <= fix_d;
            in_ready  <= in_ready_d;
            fld_valid <= fld_valid_d;
            fld_num   <= fld_num_d;
            fld_wt    <= fld_wt_d;
            fld_value <= fld_value_d;
            err       <= err_d;
            err_code  <= err_code_d;
        end
    end

`ifdef PB_SKIP_STATS_EN
    // Saturating counters of dropped fields and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (skip_evt_c && (skip_cnt != 16'hFFFF)) begin
                skip_cnt <= skip_cnt + 16'd1;
            end
            if (err_d && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pb_wire_sequencer.sv
// Scoreboard bench for pb_wire_sequencer: directed byte streams push expected
// field/payload/error events; a negedge monitor pops and compares them.
module tb_pb_wire_sequencer;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int          kind;   // 0 field, 1 payload, 2 error
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_data;
    logic [31:0] known_mask;
    logic        fld_valid, fld_ready;
    logic [4:0]  fld_num;
    logic [2:0]  fld_wt;
    logic [63:0] fld_value;
    logic        pay_valid, pay_last, err;
    logic [7:0]  pay_data;
    logic [1:0]  err_code;
`ifdef PB_SKIP_STATS_EN
    logic [15:0] skip_cnt, err_cnt;
`endif

    exp_t    expq[$];
    int      errors = 0;
    int      checks = 0;
    byte_q_t q;

    always #5 clk = ~clk;

    pb_wire_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .known_mask (known_mask),
        .fld_valid  (fld_valid),
        .fld_ready  (fld_ready),
        .fld_num    (fld_num),
        .fld_wt     (fld_wt),
        .fld_value  (fld_value),
        .pay_valid  (pay_valid),
        .pay_data   (pay_data),
        .pay_last   (pay_last),
        .err        (err),
        .err_code   (err_code)
`ifdef PB_SKIP_STATS_EN
        ,
        .skip_cnt   (skip_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        expq.push_back(e);
    endtask

    task automatic take(input int kind, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind=%0d a=%0h b=%0h c=%0h, expected no event", kind, a, b, c);
        end else begin
            e = expq.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_a", a, e.a);
            chk("event_b", b, e.b);
            chk("event_c", c, e.c);
        end
    endtask

    // Monitor: every presented event is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fld_valid && fld_ready) take(0, 64'(fld_num), 64'(fld_wt), fld_value);
            if (pay_valid)              take(1, 64'(pay_data), 64'(pay_last), 64'h0);
            if (err)                    take(2, 64'(err_code), 64'h0, 64'h0);
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h in_ready=0, expected 1", d);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t bytes, input logic last);
        for (int i = 0; i < bytes.size(); i++) begin
            send(bytes[i], last && (i == bytes.size() - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        known_mask = 32'h0;
        fld_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fld_valid", 64'(fld_valid), 64'd0);
        chk("rst_fld_fields", {fld_value[55:0] | 56'(fld_num) | 56'(fld_wt), 8'h0}, 64'd0);
        chk("rst_pay", 64'({pay_valid, pay_data, pay_last}), 64'd0);
        chk("rst_err", 64'({err, err_code}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // varint 150 on field 1
        known_mask = 32'h0000_0002;
        push(0, 1, 0, 150);
        q = '{8'h08, 8'h96, 8'h01}; send_seq(q, 1'b1);

        // length-delimited field 2 with three payload bytes
        known_mask = 32'h0000_0004;
        push(0, 2, 2, 3);
        push(1, 8'h61, 0, 0);
        push(1, 8'h62, 0, 0);
        push(1, 8'h63, 1, 0);
        q = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63}; send_seq(q, 1'b1);

        // unknown fixed32 field 3 dropped, then field 1 = 5
        known_mask = 32'h0000_0002;
        push(0, 1, 0, 5);
        q = '{8'h1D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h05}; send_seq(q, 1'b1);
`ifdef PB_SKIP_STATS_EN
        chk("skip_cnt_after_fixed32", 64'(skip_cnt), 64'd1);
`endif

        // known fixed64 on field 4 and fixed32 on field 5
        known_mask = 32'h0000_0030;
        push(0, 4, 1, 64'h0807_0605_0403_0201);
        push(0, 5, 5, 64'h0000_0000_1234_5678);
        q = '{8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h2D, 8'h78, 8'h56, 8'h34, 8'h12};
        send_seq(q, 1'b1);

        // zero-length field 2: header only, then field 1 = 1
        known_mask = 32'h0000_0006;
        push(0, 2, 2, 0);
        push(0, 1, 0, 1);
        q = '{8'h12, 8'h00, 8'h08, 8'h01}; send_seq(q, 1'b1);

        // 11-byte varint overflows; rest of message dropped; next decodes
        known_mask = 32'h0000_0002;
        push(2, 1, 0, 0);
        q = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'h01};
        send_seq(q, 1'b1);
        chk("err_code_hold", 64'(err_code), 64'd1);
        push(0, 1, 0, 150);
        q = '{8'h08, 8'h96, 8'h01}; send_seq(q, 1'b1);

        // illegal wire type 3, drained; then truncated payload
        push(2, 2, 0, 0);
        q = '{8'h0B, 8'h00}; send_seq(q, 1'b1);
        known_mask = 32'h0000_0004;
        push(0, 2, 2, 5);
        push(1, 8'h61, 0, 0);
        push(2, 3, 0, 0);
        q = '{8'h12, 8'h05, 8'h61}; send_seq(q, 1'b1);
        @(posedge clk); #1;
`ifdef PB_SKIP_STATS_EN
        chk("skip_cnt_mid", 64'(skip_cnt), 64'd1);
        chk("err_cnt_mid", 64'(err_cnt), 64'd3);
`endif

        // back-pressure: event held for 5 cycles, next key byte waits
        known_mask = 32'h0000_0002;
        fld_ready  = 1'b0;
        q = '{8'h08, 8'h96, 8'h01}; send_seq(q, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h08;
        for (int i = 0; i < 5; i++) begin
            chk("stall_fld_valid", 64'(fld_valid), 64'd1);
            chk("stall_fld_value", fld_value, 64'd150);
            chk("stall_fld_num", 64'(fld_num), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        push(0, 1, 0, 150);
        push(0, 1, 0, 7);
        fld_ready = 1'b1;
        send(8'h08, 1'b0);
        send(8'h07, 1'b1);

        // reset mid-field abandons it
        q = '{8'h08, 8'h96}; send_seq(q, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_err_code", 64'(err_code), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
`ifdef PB_SKIP_STATS_EN
        chk("midrst_counters", 64'({skip_cnt, err_cnt}), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(0, 1, 0, 3);
        q = '{8'h08, 8'h03}; send_seq(q, 1'b1);

        // field number 32 is out of range even with all mask bits set
        known_mask = 32'hFFFF_FFFF;
        push(0, 1, 0, 42);
        q = '{8'h80, 8'h02, 8'h01, 8'h08, 8'h2A}; send_seq(q, 1'b1);
`ifdef PB_SKIP_STATS_EN
        chk("skip_cnt_final", 64'(skip_cnt), 64'd1);
        chk("err_cnt_final", 64'(err_cnt), 64'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
